// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// -------------------
// This block shares the single register-file write port between two writeback
// requesters: execute (A) and load (B). It also keeps a busy scoreboard of the
// destination registers that still have loads in flight, and it reports read
// hazards for the rs1/rs2 registers being decoded.
//
// Grant rules:
//   - B has priority.
//   - If A has lost STARVE_LIMIT consecutive cycles, A wins the next grant.
// The accepted write reaches the register file one cycle after acceptance.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_rd/a_data       execute writeback request
//   a_ready                   execute request accepted this cycle
//   b_valid/b_rd/b_data       load writeback request
//   b_ready                   load request accepted this cycle
//   ld_issue/ld_rd            load issued; mark ld_rd busy
//   rs1, rs2                  source registers being decoded
//   hazard1, hazard2          rs1/rs2 has a load pending
//   rf_write/rf_rd/rf_data    registered register-file write port
//   err                       sticky: load writeback to a non-busy register
//
// Optional feature, macro WB_FWD_EN:
//   Adds fwd1_valid/fwd1_data and fwd2_valid/fwd2_data. These let decode
//   bypass the write that lands in the register file this cycle.

module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            ld_issue,
  input  logic [4:0]      ld_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            rf_write,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            err
`ifdef WB_FWD_EN
  ,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      starve_cnt_reg;
  logic [3:0]      starve_cnt_next;
  logic [31:0]     busy_reg;
  logic [31:0]     busy_next;
  logic            rf_write_reg;
  logic [4:0]      rf_rd_reg;
  logic [XLEN-1:0] rf_data_reg;
  logic            err_reg;
  logic            err_next;
  logic            grant_a;
  logic            grant_b;

  // Combinational grant. Nothing is accepted while reset is held, so any
  // request presented during reset is dropped.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (starve_cnt_reg == LIMIT) grant_a = 1'b1;
        else                         grant_b = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // The starvation counter counts A losses and saturates at the limit.
  // It clears once A is served, or when A stops asking.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!a_valid || grant_a)        starve_cnt_next = 4'd0;
    else if (starve_cnt_reg < LIMIT) starve_cnt_next = starve_cnt_reg + 4'd1;
  end

  // Busy scoreboard, one bit per register.
  // A new load issue overrides a same-cycle load writeback to the same
  // register: the newer load is still outstanding. Bit 0 is tied low.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        assign busy_next[gi] = (ld_issue && (ld_rd == 5'(gi))) ? 1'b1 :
                               (grant_b  && (b_rd  == 5'(gi))) ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  // A load writeback is only legal for a register the scoreboard says is busy.
  assign err_next = err_reg | (grant_b && (b_rd != 5'd0) && !busy_reg[b_rd]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_reg   <= 1'b0;
      rf_rd_reg      <= 5'd0;
      rf_data_reg    <= '0;
      busy_reg       <= '0;
      starve_cnt_reg <= 4'd0;
      err_reg        <= 1'b0;
    end else begin
      busy_reg       <= busy_next;
      starve_cnt_reg <= starve_cnt_next;
      err_reg        <= err_next;
      rf_write_reg   <= 1'b0;
      // A transfer to x0 is accepted but never reaches the register file.
      // In that case the address/data outputs keep their previous values.
      if (grant_a && (a_rd != 5'd0)) begin
        rf_write_reg <= 1'b1;
        rf_rd_reg    <= a_rd;
        rf_data_reg  <= a_data;
      end else if (grant_b && (b_rd != 5'd0)) begin
        rf_write_reg <= 1'b1;
        rf_rd_reg    <= b_rd;
        rf_data_reg  <= b_data;
      end
    end
  end

  assign rf_write = rf_write_reg;
  assign rf_rd    = rf_rd_reg;
  assign rf_data  = rf_data_reg;
  assign err      = err_reg;
  assign hazard1  = busy_reg[rs1];
  assign hazard2  = busy_reg[rs2];

`ifdef WB_FWD_EN
  assign fwd1_valid = rf_write_reg && (rs1 != 5'd0) && (rf_rd_reg == rs1);
  assign fwd1_data  = rf_data_reg;
  assign fwd2_valid = rf_write_reg && (rs2 != 5'd0) && (rf_rd_reg == rs2);
  assign fwd2_data  = rf_data_reg;
`endif

endmodule
